// File: rtl/fifo_rr_drain.sv
// Round-robin drain controller: pops one FIFO at a time in bounded bursts and
// forwards each word on a registered valid/ready stream tagged with its source.
module fifo_rr_drain #(
  parameter int N_DTPS     = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int MAX_BURST  = 4,
  parameter int IDXW       = $clog2(N_DTPS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_en,
  input  logic [N_DTPS-1:0]            is_fifo_empty,
  input  logic [N_DTPS*FIFO_WIDTH-1:0] out_fifo,
  output logic [N_DTPS-1:0]            i_pop,
  output logic [FIFO_WIDTH-1:0]        o_data,
  output logic [IDXW-1:0]              o_src,
  output logic                         o_valid,
  input  logic                         o_ready,
  output logic                         o_busy
);

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  localparam logic [1:0] ST_ARB  = 2'd0;
  localparam logic [1:0] ST_POP  = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [IDXW-1:0]       ptr_q, ptr_d;
  logic [IDXW-1:0]       grant_q, grant_d;
  logic [BW-1:0]         burst_cnt_q, burst_cnt_d;
  logic [N_DTPS-1:0]     pop_q, pop_d;
  logic [FIFO_WIDTH-1:0] data_q, data_d;
  logic [IDXW-1:0]       src_q, src_d;
  logic                  valid_q, valid_d;

  logic [FIFO_WIDTH-1:0] words [N_DTPS];
  logic [IDXW-1:0]       sel;
  logic                  found;
  logic                  burst_more;

  always_comb begin
    for (int k = 0; k < N_DTPS; k++) begin
      words[k] = out_fifo[k*FIFO_WIDTH +: FIFO_WIDTH];
    end
  end

  // Rotating priority scan starting at ptr; the index wraps at N_DTPS, not at
  // a power of two, so non-power-of-two banks rotate correctly.
  always_comb begin
    int              idx;
    logic [IDXW-1:0] cand;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < N_DTPS; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N_DTPS) idx = idx - N_DTPS;
      cand = IDXW'(idx);
      if (!found && !is_fifo_empty[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  assign burst_more = (int'(burst_cnt_q) + 1 < MAX_BURST) &&
                      !is_fifo_empty[grant_q] && i_en;

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    burst_cnt_d = burst_cnt_q;
    pop_d       = '0;
    data_d      = data_q;
    src_d       = src_q;
    valid_d     = valid_q;

    case (state_q)
      ST_ARB: begin
        if (i_en && found) begin
          grant_d     = sel;
          pop_d[sel]  = 1'b1;
          burst_cnt_d = '0;
          state_d     = ST_POP;
        end
      end
      ST_POP: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        data_d  = words[grant_q];
        src_d   = grant_q;
        valid_d = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (o_ready) begin
          valid_d = 1'b0;
          if (burst_more) begin
            burst_cnt_d    = burst_cnt_q + BW'(1);
            pop_d[grant_q] = 1'b1;
            state_d        = ST_POP;
          end else begin
            ptr_d   = (grant_q == IDXW'(N_DTPS - 1)) ? '0 : grant_q + IDXW'(1);
            state_d = ST_ARB;
          end
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ARB;
      ptr_q       <= '0;
      grant_q     <= '0;
      burst_cnt_q <= '0;
      pop_q       <= '0;
      data_q      <= '0;
      src_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      burst_cnt_q <= burst_cnt_d;
      pop_q       <= pop_d;
      data_q      <= data_d;
      src_q       <= src_d;
      valid_q     <= valid_d;
    end
  end

  assign i_pop   = pop_q;
  assign o_data  = data_q;
  assign o_src   = src_q;
  assign o_valid = valid_q;
  assign o_busy  = (state_q != ST_ARB);

endmodule

// File: tb/tb_fifo_rr_drain.sv
// Self-checking bench: models the FIFO bank and predicts the drain order from
// the round-robin/burst rules at transaction level.
module tb_fifo_rr_drain;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int MB = 2;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_en = 1'b0;
  logic             o_ready = 1'b1;
  logic             fifo_clr = 1'b0;
  logic [N-1:0]     is_fifo_empty;
  logic [N*W-1:0]   out_fifo;
  logic [N-1:0]     i_pop;
  logic [W-1:0]     o_data;
  logic [IW-1:0]    o_src;
  logic             o_valid;
  logic             o_busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] mem [N][64];
  int           head [N];
  int           tail [N];
  logic [W-1:0] rdata [N];

  int got_d[$], got_s[$], exp_d[$], exp_s[$];

  logic         hold_prev = 1'b0;
  logic [W-1:0] pd;
  logic [IW-1:0] ps;

  fifo_rr_drain #(.N_DTPS(N), .FIFO_WIDTH(W), .MAX_BURST(MB), .IDXW(IW)) dut (
    .clk(clk), .rst_n(rst_n), .i_en(i_en), .is_fifo_empty(is_fifo_empty),
    .out_fifo(out_fifo), .i_pop(i_pop), .o_data(o_data), .o_src(o_src),
    .o_valid(o_valid), .o_ready(o_ready), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // FIFO bank model: a pop at an edge loads the head word into the read register.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      is_fifo_empty[k]     = (head[k] == tail[k]);
      out_fifo[k*W +: W]   = rdata[k];
    end
  end

  always @(posedge clk) begin
    if (i_pop !== '0) begin
      n_cmp++;
      if ($countones(i_pop) != 1) begin
        n_err++;
        $display("FAIL pop_onehot: i_pop=%b required at most one bit", i_pop);
      end
    end
    for (int k = 0; k < N; k++) begin
      if (fifo_clr) head[k] <= tail[k];
      else if (i_pop[k]) begin
        n_cmp++;
        if (head[k] == tail[k]) begin
          n_err++;
          $display("FAIL pop_empty: pop to empty fifo %0d", k);
        end else begin
          rdata[k] <= mem[k][head[k] % 64];
          head[k]  <= head[k] + 1;
        end
      end
    end
  end

  // Output monitor: collects accepted words and checks stability under backpressure.
  always @(negedge clk) begin
    if (rst_n && hold_prev) begin
      n_cmp++;
      if (!o_valid || o_data !== pd || o_src !== ps) begin
        n_err++;
        $display("FAIL hold_stable: got v=%b d=%h s=%0d required v=1 d=%h s=%0d",
                 o_valid, o_data, o_src, pd, ps);
      end
    end
    hold_prev = rst_n && o_valid && !o_ready;
    pd = o_data;
    ps = o_src;
    if (rst_n && o_valid && o_ready) begin
      got_d.push_back(int'(o_data));
      got_s.push_back(int'(o_src));
    end
  end

  task automatic push(input int k, input logic [W-1:0] d);
    mem[k][tail[k] % 64] = d;
    tail[k]++;
  endtask

  task automatic reset_all();
    rst_n    = 1'b0;
    i_en     = 1'b0;
    o_ready  = 1'b1;
    fifo_clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    fifo_clr = 1'b0;
    rst_n    = 1'b1;
    got_d.delete();
    got_s.delete();
  endtask

  // Reference: repeatedly grant the first non-empty FIFO from ptr, take up to
  // MB words while it stays non-empty, then move ptr past the grantee.
  task automatic build_expected(input int start_ptr);
    int lh [N];
    int p, g;
    exp_d.delete();
    exp_s.delete();
    for (int k = 0; k < N; k++) lh[k] = head[k];
    p = start_ptr;
    while (1) begin
      g = -1;
      for (int i = 0; i < N; i++) begin
        if (g < 0 && lh[(p + i) % N] != tail[(p + i) % N]) g = (p + i) % N;
      end
      if (g < 0) break;
      for (int b = 0; b < MB && lh[g] != tail[g]; b++) begin
        exp_d.push_back(int'(mem[g][lh[g] % 64]));
        exp_s.push_back(g);
        lh[g]++;
      end
      p = (g + 1) % N;
    end
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    int c = 0;
    while (got_d.size() < exp_d.size() && c < budget) begin
      @(posedge clk);
      #1;
      o_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      c++;
    end
    o_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic compare_got(input string name);
    n_cmp++;
    if (got_d.size() != exp_d.size()) begin
      n_err++;
      $display("FAIL %s_count: got %0d words required %0d", name, got_d.size(), exp_d.size());
    end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      n_cmp++;
      if (got_d[i] !== exp_d[i] || got_s[i] !== exp_s[i]) begin
        n_err++;
        $display("FAIL %s_word%0d: got %h/src%0d required %h/src%0d",
                 name, i, got_d[i], got_s[i], exp_d[i], exp_s[i]);
      end
    end
  endtask

  task automatic test_reset();
    int c;
    reset_all();
    @(negedge clk);
    n_cmp++;
    if ({i_pop, o_valid, o_busy, o_data, o_src} !== '0) begin
      n_err++;
      $display("FAIL reset_idle: pop=%b v=%b busy=%b d=%h s=%0d required all zero",
               i_pop, o_valid, o_busy, o_data, o_src);
    end
    for (int k = 0; k < N; k++)
      for (int n = 0; n < 3; n++) push(k, W'(k * 256 + n));
    o_ready = 1'b0;
    i_en    = 1'b1;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!o_valid && c < 10);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({i_pop, o_valid, o_busy, o_data, o_src} !== '0 || c >= 10) begin
      n_err++;
      $display("FAIL reset_async: pop=%b v=%b busy=%b d=%h s=%0d required all zero",
               i_pop, o_valid, o_busy, o_data, o_src);
    end
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    o_ready = 1'b1;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (i_pop == '0 && c < 10);
    n_cmp++;
    if (i_pop !== 4'b0001) begin
      n_err++;
      $display("FAIL reset_first_grant: i_pop=%b required 0001", i_pop);
    end
  endtask

  task automatic test_single_source();
    int fp = -1, fv = -1, np = 0;
    reset_all();
    push(2, 16'hA001);
    push(2, 16'hA002);
    build_expected(0);
    i_en = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (i_pop[2]) begin
        if (fp < 0) fp = c;
        np++;
      end
      if (o_valid && fv < 0) fv = c;
    end
    n_cmp++;
    if (fp != 1 || fv != 3) begin
      n_err++;
      $display("FAIL single_latency: pop at %0d valid at %0d required 1 and 3", fp, fv);
    end
    n_cmp++;
    if (np != 2) begin
      n_err++;
      $display("FAIL single_pops: got %0d pops required 2", np);
    end
    compare_got("single");
  endtask

  task automatic test_round_robin();
    int rr [12] = '{'h000, 'h001, 'h100, 'h101, 'h200, 'h201,
                    'h300, 'h301, 'h002, 'h102, 'h202, 'h302};
    reset_all();
    for (int k = 0; k < N; k++)
      for (int n = 0; n < 3; n++) push(k, W'(k * 256 + n));
    exp_d.delete();
    exp_s.delete();
    for (int i = 0; i < 12; i++) begin
      exp_d.push_back(rr[i]);
      exp_s.push_back(rr[i] >> 8);
    end
    i_en = 1'b1;
    wait_done(200, 1'b0);
    compare_got("round_robin");
  endtask

  task automatic test_backpressure();
    int c = 0;
    reset_all();
    push(1, 16'h1234);
    push(1, 16'h1235);
    push(1, 16'h1236);
    build_expected(0);
    o_ready = 1'b0;
    i_en    = 1'b1;
    do begin
      @(negedge clk);
      c++;
    end while (!o_valid && c < 10);
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if ({o_valid, o_data, o_src, i_pop} !== {1'b1, 16'h1234, 2'd1, 4'b0000}) begin
        n_err++;
        $display("FAIL bp_hold%0d: v=%b d=%h s=%0d pop=%b required 1/1234/1/0000",
                 i, o_valid, o_data, o_src, i_pop);
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 o_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (i_pop !== 4'b0010) begin
      n_err++;
      $display("FAIL bp_next_pop: i_pop=%b required 0010", i_pop);
    end
    wait_done(100, 1'b0);
    compare_got("backpressure");
  endtask

  task automatic test_wrap_skip();
    reset_all();
    push(2, 16'h22AA);
    build_expected(0);
    i_en = 1'b1;
    wait_done(100, 1'b0);
    i_en = 1'b0;
    got_d.delete();
    got_s.delete();
    push(1, 16'h11BB);
    push(2, 16'h22CC);
    build_expected(3);
    n_cmp++;
    if (exp_s.size() != 2 || exp_s[0] != 1) begin
      n_err++;
      $display("FAIL wrap_model: reference order does not start at fifo 1");
    end
    i_en = 1'b1;
    wait_done(100, 1'b0);
    compare_got("wrap_skip");
  endtask

  task automatic test_enable_drop();
    int c = 0, np = 0;
    reset_all();
    push(0, 16'h0A00);
    push(0, 16'h0A01);
    push(0, 16'h0A02);
    push(1, 16'h1B00);
    i_en = 1'b1;
    do begin
      @(negedge clk);
      c++;
    end while (i_pop == '0 && c < 10);
    @(posedge clk);
    #1 i_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i_pop != '0) np++;
    end
    n_cmp++;
    if (np != 0 || got_d.size() != 1) begin
      n_err++;
      $display("FAIL en_drop_idle: pops=%0d words=%0d required 0 and 1", np, got_d.size());
    end
    n_cmp++;
    if (got_d.size() < 1 || got_d[0] !== 'h0A00 || got_s[0] !== 0) begin
      n_err++;
      $display("FAIL en_drop_word: first word not 0a00 from fifo 0");
    end
    @(posedge clk);
    #1;
    build_expected(1);
    exp_d.push_front('h0A00);
    exp_s.push_front(0);
    i_en = 1'b1;
    wait_done(200, 1'b0);
    compare_got("en_drop");
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      reset_all();
      for (int k = 0; k < N; k++) begin
        int cnt = $urandom_range(0, 6);
        for (int n = 0; n < cnt; n++) push(k, W'($urandom));
      end
      build_expected(0);
      i_en = 1'b1;
      wait_done(600, 1'b1);
      compare_got($sformatf("random%0d", r));
    end
  endtask

  initial begin
    test_reset();
    test_single_source();
    test_round_robin();
    test_backpressure();
    test_wrap_skip();
    test_enable_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_rr_drain.md
# fifo_rr_drain

Round-robin drain controller for the bank of N_DTPS parallel 16-bit FIFOs. It watches each FIFO's empty flag, pops one FIFO at a time with a bounded burst length, and forwards each popped word onto a single registered valid/ready output stream tagged with its source index. It sits between the FIFO bank's `out_fifo`/`i_pop`/`is_fifo_empty` side and the downstream single-lane consumer.

## Interface
- N_DTPS, 4, number of FIFOs (2..16)
- FIFO_WIDTH, 16, bits per FIFO word
- MAX_BURST, 4, max consecutive words taken from one FIFO per grant (>=1)
- IDXW, $clog2(N_DTPS), width of source index
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_en  in  1  when 0, no new grant is started; an in-flight word still completes
- is_fifo_empty  in  N_DTPS  empty flag per FIFO
- out_fifo  in  N_DTPS*FIFO_WIDTH  FIFO read data, slice k = bits [(k+1)*FIFO_WIDTH-1 : k*FIFO_WIDTH]
- i_pop  out  N_DTPS  registered one-hot pop strobe, at most one bit high
- o_data  out  FIFO_WIDTH  output word
- o_src  out  IDXW  index of FIFO o_data came from
- o_valid  out  1  o_data/o_src valid
- o_ready  in  1  downstream accepts when o_valid && o_ready
- o_busy  out  1  high in any state other than ARB

## Operation
- FIFO contract: a pop strobed during cycle t updates the FIFO at the t/t+1 edge; popped word is on its out_fifo slice during t+1; is_fifo_empty reflects the pop from t+1.
- State machine: ARB, POP, LOAD, HOLD.
- ARB: if i_en and any FIFO non-empty, select first non-empty index scanning ptr, ptr+1, ... mod N_DTPS; register grant<=sel, i_pop<=onehot(sel), burst_cnt<=0, go POP. Otherwise stay, i_pop=0.
- POP: i_pop high for exactly this cycle; next state LOAD, i_pop<=0.
- LOAD: o_data<=out_fifo slice[grant], o_src<=grant, o_valid<=1, go HOLD.
- HOLD: wait for o_ready. On acceptance: o_valid<=0; if burst_cnt+1<MAX_BURST and !is_fifo_empty[grant] and i_en, burst_cnt++, i_pop<=onehot(grant), go POP; else ptr<=(grant+1) mod N_DTPS, go ARB.
- ptr wraps N_DTPS-1 -> 0; non-power-of-two N_DTPS must wrap correctly.
- A pop is never issued to a FIFO whose empty flag is 1 in the deciding cycle.
- Pushes into other FIFOs during a burst do not pre-empt it; they are served in rotation order.
- i_en falling during POP/LOAD/HOLD: current word is delivered, then return to ARB and idle.
- o_data/o_src stable while o_valid && !o_ready.

## Timing
- Reset (asynchronous, rst_n=0): state=ARB, ptr=0, grant=0, burst_cnt=0, i_pop=0, o_valid=0, o_data=0, o_src=0, o_busy=0.
- Latency: FIFO non-empty seen in ARB cycle t -> i_pop high in t+1 -> o_valid high from t+3.
- Throughput with o_ready=1: one word per 3 cycles within a burst (HOLD->POP->LOAD), 4 cycles across grants (extra ARB cycle).
- Reset asserted mid-operation: all outputs return to reset values immediately; a word popped but not yet accepted is lost (documented, not recovered).
- o_ready held 0: stay in HOLD indefinitely, no further pops.

## Test plan
- Reset: rst_n=0 mid-burst with o_valid=1 -> same cycle i_pop=0, o_valid=0, o_busy=0; after release first grant goes to FIFO 0 when all non-empty.
- Single source: N_DTPS=4, MAX_BURST=4, only FIFO 2 holds 0xA001,0xA002 -> output 0xA001,0xA002 with o_src=2, exactly two i_pop[2] pulses, first o_valid 3 cycles after the ARB cycle.
- Round-robin + burst: MAX_BURST=2, FIFOs 0..3 each hold 3 words (0xk0n) -> order 0x000,0x001,0x100,0x101,0x200,0x201,0x300,0x301,0x002,0x102,0x202,0x302.
- Backpressure: o_ready=0 for 10 cycles with o_valid=1 -> o_data/o_src unchanged, no i_pop; o_ready=1 -> accept, next pop follows next cycle.
- Wrap / skip: ptr=3, FIFO 3 empty, FIFOs 1 and 2 non-empty -> grant 1 (scan 3,0,1), then 2.
- Enable/empty edge: i_en dropped in LOAD -> word delivered, then no i_pop while i_en=0; FIFO emptied by last pop mid-burst -> no pop to empty FIFO, rotate to next.
